// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS up-counting stopwatch: state encoding,
// digit limits and BCD helpers used by the top-level match logic.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned SEC_UNITS_MAX = 9;
  localparam int unsigned SEC_TENS_MAX  = 5;
  localparam int unsigned MIN_UNITS_MAX = 9;
  localparam int unsigned MIN_TENS_MAX  = 5;

  // Field order matches the {target_min, target_sec} concatenation.
  typedef struct packed {
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
  } mmss_t;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d, input int unsigned max);
    return (d == 4'(max)) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic mmss_valid(input mmss_t t);
    return (t.min1 <= 4'(MIN_TENS_MAX))  && (t.min0 <= 4'(MIN_UNITS_MAX)) &&
           (t.sec1 <= 4'(SEC_TENS_MAX))  && (t.sec0 <= 4'(SEC_UNITS_MAX));
  endfunction

  function automatic logic mmss_at_max(input mmss_t t);
    return (t.min1 == 4'(MIN_TENS_MAX))  && (t.min0 == 4'(MIN_UNITS_MAX)) &&
           (t.sec1 == 4'(SEC_TENS_MAX))  && (t.sec0 == 4'(SEC_UNITS_MAX));
  endfunction

  // Value the digit chain will hold after one count; wraps 59:59 -> 00:00.
  function automatic mmss_t mmss_next(input mmss_t t);
    mmss_t r;
    logic  c0, c1, c2;
    c0     = (t.sec0 == 4'(SEC_UNITS_MAX));
    c1     = c0 && (t.sec1 == 4'(SEC_TENS_MAX));
    c2     = c1 && (t.min0 == 4'(MIN_UNITS_MAX));
    r.sec0 = bcd_inc(t.sec0, SEC_UNITS_MAX);
    r.sec1 = c0 ? bcd_inc(t.sec1, SEC_TENS_MAX)  : t.sec1;
    r.min0 = c1 ? bcd_inc(t.min0, MIN_UNITS_MAX) : t.min0;
    r.min1 = c2 ? bcd_inc(t.min1, MIN_TENS_MAX)  : t.min1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_up_digit.sv
// One up-counting BCD digit with a synchronous clear and a combinational
// carry-enable out, chained to form the MM:SS counter.
module bcd_up_digit #(
  parameter int unsigned MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       CE,
  output logic [3:0] counter,
  output logic       CEO
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  logic [3:0] counter_q;
  logic [3:0] counter_d;

  always_comb begin
    counter_d = counter_q;
    if (clr) begin
      counter_d = 4'd0;
    end else if (CE) begin
      counter_d = (counter_q == MAX_V) ? 4'd0 : counter_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_q <= 4'd0;
    end else begin
      counter_q <= counter_d;
    end
  end

  assign counter = counter_q;
  assign CEO     = (counter_q == MAX_V) && CE;

endmodule

// File: rtl/mmss_up_counter.sv
// MM:SS BCD stopwatch counting up to a latched target on the 1 Hz enable,
// with an IDLE/RUN/PAUSE/DONE control FSM and optional 59:59 wrap.
module mmss_up_counter
  import timer_pkg::*;
#(
  parameter bit WRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CE,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic [7:0] target_min,
  input  logic [7:0] target_sec,
  output logic [3:0] sec0,
  output logic [3:0] sec1,
  output logic [3:0] min0,
  output logic [3:0] min1,
  output logic       running,
  output logic       done,
  output logic       wrap,
  output logic       CEO
);

  state_e            state_q;
  mmss_t             target_q;
  logic              running_q;
  logic              done_q;
  logic              wrap_q;

  logic [3:0][3:0]   digit;
  logic [4:0]        carry_en;
  mmss_t             count;
  mmss_t             count_inc;
  mmss_t             target_in;
  logic              in_run;
  logic              at_max;
  logic              tick;
  logic              inc_match;
  logic              saturate;
  logic              start_match;
  logic              roll_over;

  assign count       = digit;
  assign count_inc   = mmss_next(count);
  assign target_in   = {target_min, target_sec};
  assign in_run      = (state_q == ST_RUN);
  assign at_max      = mmss_at_max(count);

  // A tick is a CE that RUN actually honours; clear and stop both swallow it.
  assign tick        = in_run && CE && !clear && !stop;
  assign inc_match   = mmss_valid(target_q) && (count_inc == target_q);
  assign saturate    = at_max && !inc_match && !WRAP;
  assign start_match = mmss_valid(target_in) && (count == target_in);
  assign carry_en[0] = tick && !saturate;

  // Carry out of the minutes-tens digit only fires on a real 59:59 -> 00:00.
  assign roll_over   = carry_en[4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      localparam int unsigned DMAX = (gi == 0) ? SEC_UNITS_MAX :
                                     (gi == 1) ? SEC_TENS_MAX  :
                                     (gi == 2) ? MIN_UNITS_MAX : MIN_TENS_MAX;
      bcd_up_digit #(
        .MAX(DMAX)
      ) u_digit (
        .clk     (clk),
        .reset   (reset),
        .clr     (clear),
        .CE      (carry_en[gi]),
        .counter (digit[gi]),
        .CEO     (carry_en[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      target_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (clear) begin
        state_q   <= ST_IDLE;
        running_q <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_PAUSE: begin
            if (start) begin
              target_q <= target_in;
              if (start_match) begin
                state_q   <= ST_DONE;
                running_q <= 1'b0;
                done_q    <= 1'b1;
              end else begin
                state_q   <= ST_RUN;
                running_q <= 1'b1;
                done_q    <= 1'b0;
              end
            end
          end
          ST_RUN: begin
            if (stop) begin
              state_q   <= ST_PAUSE;
              running_q <= 1'b0;
              done_q    <= 1'b0;
            end else if (CE) begin
              if (inc_match || saturate) begin
                state_q   <= ST_DONE;
                running_q <= 1'b0;
                done_q    <= 1'b1;
              end else begin
                wrap_q <= roll_over;
              end
            end
          end
          ST_DONE: begin
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end
          default: begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sec0    = digit[0];
  assign sec1    = digit[1];
  assign min0    = digit[2];
  assign min1    = digit[3];
  assign running = running_q;
  assign done    = done_q;
  assign wrap    = wrap_q;
  assign CEO     = at_max && CE && in_run;

endmodule

// File: doc/mmss_up_counter.md
Name: mmss_up_counter

Overview:
- Up-counting MM:SS BCD stopwatch chain.
- Counts elapsed seconds from 00:00 towards a latched target, driven by the shared 1 Hz clock-enable (CE) in the single clk domain.
- Sits beside the down-counting countdown digit chain and drives the same 7-segment display mux.
- Contains a control FSM (IDLE/RUN/PAUSE/DONE) and cascaded mod-10/mod-6 up digits with carry-enable outputs.

Parameters:
- WRAP, 0: behaviour at 59:59 with no target match. 0 = saturate and enter DONE; 1 = wrap to 00:00 and pulse wrap.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- CE  in  1  1 Hz count enable, one clk cycle wide
- start  in  1  level-sampled start/resume request
- stop  in  1  pause request
- clear  in  1  synchronous clear to 00:00 and IDLE
- target_min  in  8  BCD target minutes {tens,units}; tens 0-5, units 0-9
- target_sec  in  8  BCD target seconds {tens,units}; tens 0-5, units 0-9
- sec0  out  4  seconds units, BCD 0-9
- sec1  out  4  seconds tens, 0-5
- min0  out  4  minutes units, 0-9
- min1  out  4  minutes tens, 0-5
- running  out  1  high in RUN
- done  out  1  high in DONE
- wrap  out  1  one-cycle pulse on 59:59 -> 00:00 (WRAP=1 only)
- CEO  out  1  combinational carry: 59:59 && CE && RUN

Behaviour:
- Reset (reset=0, asynchronous):
  - all digits 0.
  - state IDLE.
  - target register 00:00.
  - running, done and wrap all 0.
- Release is synchronous to clk.
- State is encoded as 2 bits: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Control priority per cycle: clear > start > stop.
- clear in any state:
  - digits go to 0 and state goes to IDLE on the next edge.
  - A CE in the same cycle is ignored.
  - The target register is kept.
- start in IDLE or PAUSE:
  - latch target_min/target_sec into the target register.
  - If the current count equals the new target, go to DONE; otherwise go to RUN.
  - No count happens in the start cycle even if CE=1.
- start in RUN: no effect; the target is not re-latched.
- start in DONE: ignored until clear.
- stop in RUN: go to PAUSE; a CE in the same cycle is dropped (no increment).
- stop in any other state: no effect.
- Counting (RUN && CE only):
  - sec0 increments each CE; 9 -> 0 with carry.
  - sec1 increments on sec0 carry; 5 -> 0 with carry.
  - min0 increments on sec1 carry; 9 -> 0.
  - min1 increments on min0 carry; 5 -> 0.
  - Each digit's carry = (digit==max) && its enable, combinational.
  - All digits update on the same edge; latency from CE to display is 1 clk.
- Target match:
  - On a RUN && CE edge, if the incremented value equals the target, the digits take that value and the state goes to DONE on the same edge.
  - done is high from the following cycle.
  - No further increments occur.
- 59:59 with CE in RUN and no match:
  - WRAP=0: digits hold 59:59, state goes to DONE.
  - WRAP=1: digits go to 00:00, wrap pulses high for 1 cycle, state stays RUN.
- Invalid target BCD (tens > 5 or units > 9): never matches; behaviour follows the WRAP rule.
- running = (state==RUN) and done = (state==DONE); both are registered decodes.

Decomposition:
- Shared package (timer_pkg):
  - state encoding constants.
  - SEC_UNITS_MAX=9, SEC_TENS_MAX=5, MIN_UNITS_MAX=9, MIN_TENS_MAX=5.
- Sub-module bcd_up_digit: parameter MAX; ports clk, reset, clr, CE, counter[3:0], CEO.
  - Up-direction digit: CEO = (counter==MAX) && CE.
  - On CE: increments, or returns to 0 when at MAX.
  - clr has priority over CE.
  - Instantiated 4 times.
- Top level holds the FSM, target register and match compare.

Test Plan:
- Reset mid-count: after 00:37, assert reset=0 asynchronously between edges -> digits 00:00, running=0 and done=0 immediately, IDLE after release.
- Basic run: target 01:05, start, 65 CE pulses -> display 01:05, done=1 and running=0 after pulse 65; further CE leaves 01:05.
- Carry chain: run to 00:59, one CE -> 01:00 on a single edge; at 09:59 one CE -> 10:00.
- Pause/resume: stop at 00:12 with CE in the same cycle -> PAUSE, 00:12 held. Then start with target 00:15 plus 3 CE -> done at 00:15. A start asserted in the same cycle as CE produces no increment.
- Priority and trivial target:
  - clear+start+CE together at 00:20 -> 00:00 and IDLE.
  - start with target 00:00 at count 00:00 -> DONE next cycle with no counting.
- Wrap/saturate with target 99:99:
  - WRAP=1: at 59:59, CE -> 00:00, wrap high 1 cycle, running=1.
  - WRAP=0: at 59:59, CE -> hold 59:59, done=1.
  - CEO high only in the 59:59 && CE && RUN cycle.
